// File: rtl/p1v_rst_pkg.sv
// Shared definitions for the P1V reset generator: FSM state encoding and
// reset-cause codes reported on rst_cause.
package p1v_rst_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_BTN  = 2'd1,
    ST_RUN  = 2'd2
  } rst_state_e;

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_BTN = 2'b01;
  localparam logic [1:0] CAUSE_WDT = 2'b10;

  // Level of an active-low button when nobody is pressing it.
  localparam logic BTN_RELEASED = 1'b1;

endpackage

// File: rtl/p1v_debounce.sv
// Multi-flop synchronizer followed by a debouncer: the output only follows the
// synchronized input after DEB_CYCLES consecutive cycles of disagreement.
module p1v_debounce
  import p1v_rst_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 800000
) (
  input  logic clk,
  input  logic res,
  input  logic din_n,
  output logic deb_n
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic [CNT_W-1:0]       cnt_p1;
  logic                   sync_out;

  assign sync_out = sync_p0[SYNC_STAGES-1];

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      sync_p0 <= {SYNC_STAGES{BTN_RELEASED}};
      cnt_p1  <= '0;
      deb_n   <= BTN_RELEASED;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], din_n};
      // Any agreeing cycle restarts the stability window.
      if (sync_out == deb_n) begin
        cnt_p1 <= '0;
      end else if (cnt_p1 == CNT_LAST) begin
        deb_n  <= sync_out;
        cnt_p1 <= '0;
      end else begin
        cnt_p1 <= cnt_p1 + 1'b1;
      end
    end
  end

endmodule

// File: rtl/p1v_rstgen.sv
// Reset conditioner feeding P1V inp_resn: debounced button, minimum hold time,
// reset-cause reporting. Define P1V_RSTGEN_WDT_EN to add the kick watchdog.
module p1v_rstgen
  import p1v_rst_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 800000,
  parameter int HOLD_CYCLES = 16000000,
  parameter int WDT_CYCLES  = 160000000
) (
  input  logic       clk,
  input  logic       res,
  input  logic       btn_n,
`ifdef P1V_RSTGEN_WDT_EN
  input  logic       wdt_kick,
`endif
  output logic       resn_out,
  output logic [1:0] rst_cause
);

  localparam logic [23:0] HOLD_LAST = 24'(HOLD_CYCLES - 1);

  rst_state_e  state;
  logic [23:0] hold_cnt;
  logic        btn_deb_n;
  logic        btn_pressed;
  logic        wdt_expire;

  p1v_debounce #(
    .SYNC_STAGES (SYNC_STAGES),
    .DEB_CYCLES  (DEB_CYCLES)
  ) u_btn_deb (
    .clk   (clk),
    .res   (res),
    .din_n (btn_n),
    .deb_n (btn_deb_n)
  );

  assign btn_pressed = (btn_deb_n != BTN_RELEASED);

`ifdef P1V_RSTGEN_WDT_EN
  localparam int WDT_W = $clog2(WDT_CYCLES + 1);
  localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] kick_sync_p0;
  logic                   kick_prev_p1;
  logic                   kick_edge;
  logic [WDT_W-1:0]       wdt_cnt;

  assign kick_edge  = kick_sync_p0[SYNC_STAGES-1] ^ kick_prev_p1;
  assign wdt_expire = (state == ST_RUN) && (wdt_cnt == WDT_LAST);

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      kick_sync_p0 <= '0;
      kick_prev_p1 <= 1'b0;
      wdt_cnt      <= '0;
    end else begin
      kick_sync_p0 <= {kick_sync_p0[SYNC_STAGES-2:0], wdt_kick};
      kick_prev_p1 <= kick_sync_p0[SYNC_STAGES-1];
      // Either kick edge counts; the timer only runs while the core is up.
      if (state != ST_RUN || kick_edge || wdt_expire) begin
        wdt_cnt <= '0;
      end else begin
        wdt_cnt <= wdt_cnt + 1'b1;
      end
    end
  end
`else
  // Watchdog compiled out: it can never expire for any legal timeout.
  assign wdt_expire = (WDT_CYCLES < 0);
`endif

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state     <= ST_HOLD;
      hold_cnt  <= '0;
      resn_out  <= 1'b0;
      rst_cause <= CAUSE_POR;
    end else begin
      case (state)
        ST_HOLD: begin
          if (btn_pressed) begin
            state     <= ST_BTN;
            hold_cnt  <= '0;
            rst_cause <= CAUSE_BTN;
          end else if (hold_cnt == HOLD_LAST) begin
            state    <= ST_RUN;
            resn_out <= 1'b1;
          end else begin
            // Leaves HOLD at HOLD_LAST, so the count never wraps.
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ST_BTN: begin
          hold_cnt <= '0;
          if (!btn_pressed) begin
            state <= ST_HOLD;
          end
        end
        ST_RUN: begin
          hold_cnt <= '0;
          // Button takes priority over a coincident watchdog expiry.
          if (btn_pressed) begin
            state     <= ST_BTN;
            resn_out  <= 1'b0;
            rst_cause <= CAUSE_BTN;
          end else if (wdt_expire) begin
            state     <= ST_HOLD;
            resn_out  <= 1'b0;
            rst_cause <= CAUSE_WDT;
          end
        end
        default: begin
          state    <= ST_HOLD;
          hold_cnt <= '0;
          resn_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_p1v_rstgen.sv
// Bench for p1v_rstgen with short timings (SYNC 2, DEB 4, HOLD 10, WDT 20).
// Edge counts are inclusive: edge 1 is the first edge that samples a new input.
module tb_p1v_rstgen;

  localparam int SYNC = 2;
  localparam int DEB  = 4;
  localparam int HOLD = 10;
  localparam int WDT  = 20;
`ifdef P1V_RSTGEN_WDT_EN
  localparam bit WDT_ON = 1'b1;
`else
  localparam bit WDT_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       res = 1'b0;
  logic       btn_n = 1'b1;
  logic       wdt_kick = 1'b0;
  logic       resn_out;
  logic [1:0] rst_cause;

  int n_cmp = 0;
  int n_bad = 0;

  p1v_rstgen #(
    .SYNC_STAGES (SYNC),
    .DEB_CYCLES  (DEB),
    .HOLD_CYCLES (HOLD),
    .WDT_CYCLES  (WDT)
  ) dut (
    .clk       (clk),
    .res       (res),
    .btn_n     (btn_n),
`ifdef P1V_RSTGEN_WDT_EN
    .wdt_kick  (wdt_kick),
`endif
    .resn_out  (resn_out),
    .rst_cause (rst_cause)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Reference model: inputs seen through SYNC-deep delay lines, the button
  // level flips after DEB consecutive disagreeing samples, and the core is
  // released at a timestamp computed when the hold period starts.
  int         m_t, m_hold_until, m_anchor, m_mis;
  bit         m_run, m_deb, m_kprev;
  logic [1:0] m_cause;
  bit         m_bq[$];
  bit         m_kq[$];

  task automatic model_reset();
    m_t = 0; m_hold_until = HOLD; m_anchor = 0; m_mis = 0;
    m_run = 0; m_deb = 1; m_kprev = 0; m_cause = 2'b00;
    m_bq.delete(); m_kq.delete();
    for (int i = 0; i < SYNC; i++) begin
      m_bq.push_back(1'b1);
      m_kq.push_back(1'b0);
    end
  endtask

  task automatic model_step();
    bit s_btn, s_kick, pressed, kedge, expire;
    m_t++;
    s_btn = m_bq.pop_front();
    m_bq.push_back(btn_n);
    s_kick = m_kq.pop_front();
    m_kq.push_back(WDT_ON ? wdt_kick : 1'b0);
    pressed = !m_deb;
    kedge   = (s_kick != m_kprev);
    m_kprev = s_kick;
    expire  = WDT_ON && m_run && (m_t == m_anchor + WDT);
    if (m_run) begin
      if (pressed) begin
        m_run = 0; m_cause = 2'b01; m_hold_until = -1;
      end else if (expire) begin
        m_run = 0; m_cause = 2'b10; m_hold_until = m_t + HOLD;
      end else if (kedge) begin
        m_anchor = m_t;
      end
    end else begin
      if (pressed) begin
        m_cause = 2'b01; m_hold_until = -1;
      end else if (m_hold_until < 0) begin
        m_hold_until = m_t + HOLD;
      end else if (m_t == m_hold_until) begin
        m_run = 1; m_anchor = m_t;
      end
    end
    if (s_btn != m_deb) begin
      m_mis++;
      if (m_mis == DEB) begin
        m_deb = s_btn;
        m_mis = 0;
      end
    end else begin
      m_mis = 0;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic count_until(input logic val, input int max, output int n);
    n = 0;
    while (1) begin
      cyc();
      n++;
      if (resn_out == val) break;
      if (n >= max) begin
        n = -1;
        break;
      end
    end
  endtask

  task automatic do_por(output int n);
    @(posedge clk);
    #1 res = 1'b1;
    btn_n = 1'b1;
    wdt_kick = 1'b0;
    #2 res = 1'b0;
    model_reset();
    count_until(1'b1, 40, n);
  endtask

  typedef struct {
    int width;
    int fall_edge;
    int rise_edge;
    int cause;
  } btn_vec_t;

  btn_vec_t vecs[6];

  initial begin
    int n, fall, rise, left;
    bit minr;

    // width of the low pulse; fall/rise edge numbers (-1 = never); final cause
    vecs[0] = '{1,  -1, -1, 0};
    vecs[1] = '{2,  -1, -1, 0};
    vecs[2] = '{3,  -1, -1, 0};
    vecs[3] = '{4,   7, 21, 1};
    vecs[4] = '{5,   7, 22, 1};
    vecs[5] = '{30,  7, 47, 1};

    #1 res = 1'b1;
    #2;
    check("reset_resn", resn_out, 0);
    check("reset_cause", rst_cause, 0);
    @(posedge clk);
    #1 res = 1'b0;
    model_reset();
    count_until(1'b1, 40, n);
    check("por_rise_edge", n, HOLD);
    check("por_cause", rst_cause, 0);

    minr = 1;
    btn_n = 1'b0;
    repeat (3) begin
      cyc();
      if (!resn_out) minr = 0;
    end
    btn_n = 1'b1;
    repeat (20) begin
      cyc();
      if (!resn_out) minr = 0;
    end
    check("glitch_resn", minr, 1);
    check("glitch_cause", rst_cause, 0);

    for (int v = 0; v < 6; v++) begin
      do_por(n);
      fall = -1;
      rise = -1;
      for (int i = 1; i <= 60; i++) begin
        btn_n = (i <= vecs[v].width) ? 1'b0 : 1'b1;
        cyc();
        if (fall < 0 && !resn_out) fall = i;
        else if (fall >= 0 && rise < 0 && resn_out) rise = i;
      end
      check($sformatf("tbl%0d_fall_edge", v), fall, vecs[v].fall_edge);
      check($sformatf("tbl%0d_rise_edge", v), rise, vecs[v].rise_edge);
      check($sformatf("tbl%0d_cause", v), rst_cause, vecs[v].cause);
    end

    do_por(n);
    btn_n = 1'b0;
    repeat (10) cyc();
    check("btn_hold_resn", resn_out, 0);
    check("btn_hold_cause", rst_cause, 1);
    #2 res = 1'b1;
    #1;
    check("async_res_resn", resn_out, 0);
    check("async_res_cause", rst_cause, 0);
    btn_n = 1'b1;
    #1 res = 1'b0;
    model_reset();
    count_until(1'b1, 40, n);
    check("async_res_rise_edge", n, HOLD);

`ifdef P1V_RSTGEN_WDT_EN
    do_por(n);
    count_until(1'b0, 60, n);
    check("wdt_fall_edge", n, WDT);
    check("wdt_cause", rst_cause, 2);
    count_until(1'b1, 40, n);
    check("wdt_low_time", n, HOLD);
    check("wdt_cause_in_run", rst_cause, 2);

    do_por(n);
    minr = 1;
    for (int i = 1; i <= 500; i++) begin
      if (i % 15 == 0) wdt_kick = ~wdt_kick;
      cyc();
      if (!resn_out) minr = 0;
    end
    check("kick_keeps_run", minr, 1);

    do_por(n);
    repeat (13) cyc();
    btn_n = 1'b0;
    repeat (6) cyc();
    check("coll_pre_resn", resn_out, 1);
    cyc();
    check("coll_resn", resn_out, 0);
    check("coll_cause", rst_cause, 1);
    btn_n = 1'b1;
`else
    do_por(n);
    minr = 1;
    repeat (100) begin
      cyc();
      if (!resn_out) minr = 0;
    end
    check("no_wdt_resn", minr, 1);
    check("no_wdt_cause", rst_cause, 0);
`endif

    // Randomized run against the reference model.
    @(posedge clk);
    #1 res = 1'b1;
    btn_n = 1'b1;
    wdt_kick = 1'b0;
    #2 res = 1'b0;
    model_reset();
    left = 0;
    for (int i = 0; i < 3000; i++) begin
      if (left == 0) begin
        btn_n = ($urandom_range(0, 3) != 0);
        left = $urandom_range(1, 12);
      end
      left--;
      if ($urandom_range(0, 24) == 0) wdt_kick = ~wdt_kick;
      cyc();
      check("rand_resn", resn_out, m_run);
      check("rand_cause", rst_cause, m_cause);
      if ($urandom_range(0, 499) == 0) begin
        res = 1'b1;
        #1;
        check("rand_res_resn", resn_out, 0);
        check("rand_res_cause", rst_cause, 0);
        #1 res = 1'b0;
        model_reset();
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
